// File: rtl/apple_io_pkg.sv
// Shared Apple-1 I/O constants: PIA/LED address map, ASCII case constants,
// and the lowercase-to-uppercase helper used by the UART receive path.
package apple_io_pkg;

    localparam logic [15:0] ADDR_KBD      = 16'hD010;
    localparam logic [15:0] ADDR_KBDCR    = 16'hD011;
    localparam logic [15:0] ADDR_DSP      = 16'hD012;
    localparam logic [15:0] ADDR_LED      = 16'hD000;
    localparam logic [15:0] ADDR_LED_KEYS = 16'hD020;

    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    // The Apple-1 character set has no lowercase, so 'a'..'z' are folded up.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= ASCII_LC_A && b <= ASCII_LC_Z)
            return b - ASCII_CASE_OFS;
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / CPU read strobe side and the keyboard
// receive buffer. master drives the strobes, slave is the buffer itself.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_error;
    logic          rd_pop;
    logic          err_clr;
    logic [7:0]    kbd_data;
    logic          kbd_ready;
    logic          cts_hold;
    logic [LW-1:0] level;
    logic          overflow;
    logic          frame_err;

    modport master (
        output rx_valid, rx_data, rx_error, rd_pop, err_clr,
        input  kbd_data, kbd_ready, cts_hold, level, overflow, frame_err
    );

    modport slave (
        input  rx_valid, rx_data, rx_error, rd_pop, err_clr,
        output kbd_data, kbd_ready, cts_hold, level, overflow, frame_err
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: register storage with combinational head read,
// modulo-DEPTH pointers and an explicit occupancy counter.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer feeding the Apple-1 keyboard port ($D010/$D011), with
// CTS flow control and sticky error flags. UART_RX_UPCASE_EN folds a..z to A..Z.
module uart_rx_fifo
    import apple_io_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CTS_MARGIN = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          push;
    logic [7:0]    wr_data;
    logic [7:0]    rd_data;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          dropped;
    logic          cts_q;
    logic          overflow_q;
    logic          frame_err_q;

    assign push = bus.rx_valid && !bus.rx_error;

`ifdef UART_RX_UPCASE_EN
    assign wr_data = to_upper(bus.rx_data);
`else
    assign wr_data = bus.rx_data;
`endif

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (wr_data),
        .pop     (bus.rd_pop),
        .rd_data (rd_data),
        .level   (level),
        .empty   (empty),
        .full    (full),
        .dropped (dropped)
    );

    // Flags: a drop in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_q       <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cts_q <= (level >= LW'(DEPTH - CTS_MARGIN)) || bus.rx_valid;

            if (dropped)
                overflow_q <= 1'b1;
            else if (bus.err_clr)
                overflow_q <= 1'b0;

            if (bus.rx_valid && bus.rx_error)
                frame_err_q <= 1'b1;
            else if (bus.err_clr)
                frame_err_q <= 1'b0;
        end
    end

    // Bit 7 always reads as 1 when a key is available, as Wozmon expects.
    assign bus.kbd_data  = empty ? 8'h00 : (rd_data | 8'h80);
    assign bus.kbd_ready = !empty;
    assign bus.cts_hold  = cts_q;
    assign bus.level     = level;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stored bytes queue their expected
// $D010 value, and a negedge monitor checks each value the CPU pops.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH      (DEPTH),
        .CTS_MARGIN (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && bus.rd_pop && bus.kbd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: popped %h with nothing expected", bus.kbd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.kbd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", bus.kbd_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; store=1 means the byte must land in the FIFO.
    task automatic step(input logic v, input logic [7:0] d, input logic e,
                        input logic p, input logic c, input logic store,
                        input logic [7:0] exp);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.rx_error = e;
        bus.rd_pop   = p;
        bus.err_clr  = c;
        if (store)
            exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_error = 1'b0;
        bus.rd_pop   = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] exp);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, exp);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_error = 1'b0;
        bus.rd_pop   = 1'b0;
        bus.err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("rst_level", 32'(bus.level), 0);
        chk("rst_ready", 32'(bus.kbd_ready), 0);
        chk("rst_data", 32'(bus.kbd_data), 32'h00);
        chk("rst_cts", 32'(bus.cts_hold), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_ferr", 32'(bus.frame_err), 0);

        push(8'h41, 8'hC1);
        chk("push_ready", 32'(bus.kbd_ready), 1);
        chk("push_data", 32'(bus.kbd_data), 32'hC1);
        chk("push_level", 32'(bus.level), 1);
        pop();
        chk("pop_ready", 32'(bus.kbd_ready), 0);
        chk("pop_data_empty", 32'(bus.kbd_data), 32'h00);
        chk("pop_level", 32'(bus.level), 0);

        // Fill to 11, then cross the CTS threshold at 12.
        for (int i = 0; i < 11; i++)
            push(8'h30 + 8'(i), 8'hB0 + 8'(i));
        idle();
        chk("cts_lvl11_level", 32'(bus.level), 11);
        chk("cts_lvl11", 32'(bus.cts_hold), 0);
        push(8'h3B, 8'hBB);
        idle();
        chk("cts_lvl12_level", 32'(bus.level), 12);
        chk("cts_lvl12", 32'(bus.cts_hold), 1);
        for (int i = 12; i < 16; i++)
            push(8'h30 + 8'(i), 8'hB0 + 8'(i));
        chk("full_level", 32'(bus.level), 16);
        chk("full_cts", 32'(bus.cts_hold), 1);
        chk("full_ovf", 32'(bus.overflow), 0);

        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_level", 32'(bus.level), 16);
        chk("ovf_set", 32'(bus.overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ovf_clr", 32'(bus.overflow), 0);

        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'hDA);
        chk("full_pushpop_level", 32'(bus.level), 16);
        chk("full_pushpop_ovf", 32'(bus.overflow), 0);
        repeat (16) pop();
        chk("drain_level", 32'(bus.level), 0);
        chk("drain_ready", 32'(bus.kbd_ready), 0);
        idle();
        chk("drain_cts", 32'(bus.cts_hold), 0);

        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ferr_set", 32'(bus.frame_err), 1);
        chk("ferr_level", 32'(bus.level), 0);
        pop();
        chk("underflow_level", 32'(bus.level), 0);
        chk("underflow_ready", 32'(bus.kbd_ready), 0);
        chk("underflow_ovf", 32'(bus.overflow), 0);
        chk("underflow_ferr", 32'(bus.frame_err), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ferr_clr", 32'(bus.frame_err), 0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ferr_set_wins", 32'(bus.frame_err), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ferr_clr2", 32'(bus.frame_err), 0);

`ifdef UART_RX_UPCASE_EN
        push(8'h61, 8'hC1);
`else
        push(8'h61, 8'hE1);
`endif
        push(8'h7B, 8'hFB);
        push(8'h40, 8'hC0);
        repeat (3) pop();

        step(1'b1, 8'h52, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD2);
        chk("empty_pushpop_level", 32'(bus.level), 1);
        pop();

        push(8'h01, 8'h81);
        push(8'h02, 8'h82);
        push(8'h03, 8'h83);
        #3 reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_level", 32'(bus.level), 0);
        chk("async_rst_ready", 32'(bus.kbd_ready), 0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'h0D, 8'h8D);
        chk("post_rst_data", 32'(bus.kbd_data), 32'h8D);
        pop();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the `uart` receiver and the Apple‑1 keyboard port (PIA.A, $D010/$D011). It replaces the single-byte flag/ack latch with a synchronous FIFO, so that pasted text and Wozmon hex loads are not lost while the 6502 is busy. It also drives the hardware flow-control line from the fill level. All logic runs on the UART master clock; the 6502-side read strobe is delivered into this domain by the integrator.

## Interface
Parameters:
- DEPTH, 16: number of entries; power of two, 4..256.
- CTS_MARGIN, 4: free entries remaining at which `cts_hold` asserts; must be 1..DEPTH-1.

Ports:
- clk  in  1  UART master clock.
- reset_n  in  1  Asynchronous, active-low reset.
- rx_valid  in  1  One-cycle strobe from the UART: byte received.
- rx_data  in  8  Received byte; sampled when `rx_valid` is high.
- rx_error  in  1  UART framing error; sampled with `rx_valid`.
- rd_pop  in  1  One-cycle pulse: the CPU consumed $D010.
- err_clr  in  1  One-cycle pulse: clear the sticky flags.
- kbd_data  out  8  $D010 read value: {1'b1, head[6:0]} when not empty, else 8'h00.
- kbd_ready  out  1  $D011 bit 7; high when not empty.
- cts_hold  out  1  High means the host must stop sending.
- level  out  $clog2(DEPTH)+1  Current occupancy, 0..DEPTH.
- overflow  out  1  Sticky flag: a byte was dropped because the FIFO was full.
- frame_err  out  1  Sticky flag: a byte was dropped because of `rx_error`.

## Operation
- Push: `rx_valid` && !`rx_error` writes `rx_data` at `wr_ptr` and increments `wr_ptr` modulo DEPTH.
- Error drop: `rx_valid` && `rx_error` discards the byte and sets `frame_err`.
- Pop: `rd_pop` && `level` != 0 increments `rd_ptr`.
- Underflow: `rd_pop` when empty is ignored. There is no state change and no flag.
- Full with push and no pop: the byte is dropped and `overflow` is set. The pointers are unchanged.
- Full with push and pop in the same cycle: both take effect. `level` stays DEPTH and `overflow` is not set.
- Empty with push and pop in the same cycle: the pop is ignored and the push takes effect, so `level` becomes 1.
- `level` is an explicit counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointer wrap-around is modulo DEPTH.
- `cts_hold` = (`level` >= DEPTH − CTS_MARGIN) || `rx_valid` pending in the current cycle. It is registered.
- `err_clr` clears `overflow` and `frame_err`. If `err_clr` coincides with a new drop event, the set wins.
- Storage is plain registers or inferred RAM with a combinational read at `rd_ptr`. Storage contents are not reset.
- `kbd_data` bit 7 is forced to 1 for Wozmon compatibility; bits 6:0 come from the stored byte.

## Timing
- Reset values: `wr_ptr`, `rd_ptr` and `level` = 0; `kbd_ready` = 0; `kbd_data` = 8'h00; `cts_hold` = 0; `overflow` = 0; `frame_err` = 0.
- Push in cycle N: `kbd_ready`, `level` and `kbd_data` update at N+1.
- Pop in cycle N: the next head byte appears on `kbd_data` at N+1. `kbd_ready` falls at N+1 if that pop emptied the FIFO.
- `cts_hold` changes one cycle after the `level` crossing.
- Throughput is one push and one pop per cycle, unconditionally.
- Reset asserted mid-operation empties the FIFO immediately. The first push after release is stored at index 0.

## Configuration
- `UART_RX_UPCASE_EN` defined: on push, bytes 8'h61..8'h7A ('a'..'z') are stored minus 8'h20, i.e. as uppercase. This matches the Apple‑1 uppercase-only character set. All other bytes are stored unchanged.
- `UART_RX_UPCASE_EN` undefined: bytes are stored verbatim.

## Structure
- Shared package `apple_io_pkg` holds:
  - the I/O address constants (KBD $D010, KBDCR $D011, DSP $D012, LED $D000, LED_KEYS $D020);
  - the ASCII constants (ASCII_LC_A = 8'h61, ASCII_LC_Z = 8'h7A, ASCII_CASE_OFS = 8'h20).
- One natural sub-module, `sync_fifo`, provides the generic storage, pointers, level counter and full/empty logic.
- `uart_rx_fifo` wraps `sync_fifo` and adds:
  - error filtering;
  - case conversion;
  - CTS threshold logic;
  - sticky flags;
  - formatting of the $D010/$D011 outputs.

## Test plan
- Reset, then push 8'h41 → next cycle `kbd_ready`=1, `kbd_data`=8'hC1, `level`=1. Pop → `kbd_ready`=0, `kbd_data`=8'h00.
- Push 16 bytes 8'h30..8'h3F with DEPTH=16 → `cts_hold`=1 once `level`>=12. A 17th push sets `overflow`=1 and keeps `level`=16. Popping all 16 returns 8'hB0..8'hBF in order.
- At full, assert push 8'h5A and pop in the same cycle → `level` stays 16, `overflow` stays 0, and 8'h5A is the last byte popped.
- Push with `rx_error`=1 → `frame_err`=1, `level` unchanged. `err_clr` clears it. `rd_pop` while empty leaves all state unchanged.
- With `UART_RX_UPCASE_EN` defined, push 8'h61, 8'h7B, 8'h40 → reads return 8'hC1, 8'hFB, 8'hC0.
- Push 3 bytes, assert `reset_n`=0 for one cycle asynchronously → `level`=0 and `kbd_ready`=0 immediately. Then push 8'h0D → reads back 8'h8D.
